// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_pkg;

  localparam int FETCH_AW = 16;
  localparam int FETCH_DW = 16;

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} fetch_state_e;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

  // Sign-extend the low off_w bits of raw to 32 bits.
  function automatic logic [31:0] sext_off(input logic [31:0] raw, input int off_w);
    logic [31:0] sh;
    sh = raw << (32 - off_w);
    return $unsigned($signed(sh) >>> (32 - off_w));
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO; flush wins over push/pop, head reads as zero when empty.
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: owns the PC, issues one outstanding memory request at a time,
// buffers instructions in a prefetch queue and applies branch/jump redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int             DW       = 16,
  parameter int             AW       = 16,
  parameter int             OFF_W    = 8,
  parameter int             QDEPTH   = 2,
  parameter logic [AW-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] ir_out,
  output logic [AW-1:0] ir_pc,
  output logic          ir_valid,
  input  logic          ir_ready,
  input  logic          br_take,
  input  logic          jmp_take,
  input  logic [AW-1:0] jmp_addr
);
  localparam int CW = $clog2(QDEPTH+1);

  fetch_state_e     state, state_next;
  logic [AW-1:0]    fetch_pc, fetch_pc_next, target;
  logic             redirect, hold, push, pop, req_next;
  logic [CW-1:0]    q_count, count_next;
  logic [AW+DW-1:0] q_head;
  logic             q_empty;

  assign redirect = jmp_take | (br_take & ir_valid);
  assign hold     = mem_req & ~mem_ack;
  assign target   = jmp_take ? jmp_addr
                             : ir_pc + AW'(sext_off(32'(ir_out), OFF_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // A redirect that catches a fetch still in flight must wait out its ack.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (redirect && hold) state_next = DRAIN;
      DRAIN:   if (mem_req && mem_ack) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    push = 1'b0;
    pop  = ir_valid & ir_ready & ~redirect;
    if (state == RUN) push = mem_req & mem_ack & ~redirect;
  end

  assign count_next    = redirect ? '0 : q_count + CW'(push) - CW'(pop);
  assign req_next      = hold | ((state_next == RUN) && (count_next < CW'(QDEPTH)));
  assign fetch_pc_next = redirect ? target : (push ? fetch_pc + AW'(1) : fetch_pc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else begin
      fetch_pc <= fetch_pc_next;
      mem_req  <= req_next;
      mem_addr <= hold ? mem_addr : fetch_pc_next;
    end
  end

  fetch_queue #(.W(AW+DW), .DEPTH(QDEPTH), .CW(CW)) u_queue (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .din   ({mem_addr, mem_rdata}),
    .dout  (q_head),
    .count (q_count),
    .empty (q_empty)
  );

  assign ir_valid        = ~q_empty;
  assign {ir_pc, ir_out} = q_head;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, mem_req, mem_ack, ir_valid, ir_ready, br_take, jmp_take;
  logic [15:0] mem_addr, mem_rdata, ir_out, ir_pc, jmp_addr;

  logic        w_reset, w_mem_req, w_mem_ack, w_ir_valid, w_ir_ready, w_br_take, w_jmp_take;
  logic [15:0] w_mem_addr, w_mem_rdata, w_ir_out, w_ir_pc, w_jmp_addr;

  fetch_unit dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir_out(ir_out), .ir_pc(ir_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .br_take(br_take),
    .jmp_take(jmp_take), .jmp_addr(jmp_addr)
  );

  fetch_unit #(.RESET_PC(16'hFFFF)) dut_wrap (
    .clk(clk), .reset(w_reset), .mem_req(w_mem_req), .mem_addr(w_mem_addr),
    .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .ir_out(w_ir_out), .ir_pc(w_ir_pc),
    .ir_valid(w_ir_valid), .ir_ready(w_ir_ready), .br_take(w_br_take),
    .jmp_take(w_jmp_take), .jmp_addr(w_jmp_addr)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: instruction queue, pending-request flag and address, next PC,
  // and a flag saying the pending fetch belongs to a stream already abandoned.
  fetch_entry_t mq[$];
  bit           m_req, m_stale;
  logic [15:0]  m_addr, m_pc;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_req = 0; m_stale = 0; m_addr = 16'h0000; m_pc = 16'h0000;
  endtask

  task automatic model_step(input bit rdy, input bit br, input bit jmp,
                            input logic [15:0] ja, input bit ack, input logic [15:0] rd);
    bit          valid, acked;
    logic [15:0] tgt, off;
    fetch_entry_t e;
    valid = (mq.size() != 0);
    acked = ack && m_req;
    if (jmp || (br && valid)) begin
      if (jmp) tgt = ja;
      else begin
        off = {{8{mq[0].instr[7]}}, mq[0].instr[7:0]};
        tgt = mq[0].pc + off;
      end
      mq.delete();
      m_pc    = tgt;
      m_stale = m_req && !acked;
    end else begin
      if (valid && rdy) void'(mq.pop_front());
      if (acked && !m_stale) begin
        e.pc = m_addr; e.instr = rd;
        mq.push_back(e);
        m_pc = m_pc + 16'h0001;
      end
      if (acked) m_stale = 0;
    end
    if (!(m_req && !acked)) begin
      m_req  = !m_stale && (mq.size() < 2);
      m_addr = m_pc;
    end
  endtask

  task automatic cycle(input bit rdy, input bit br, input bit jmp,
                       input logic [15:0] ja, input bit ack, input logic [15:0] rd);
    ir_ready = rdy; br_take = br; jmp_take = jmp; jmp_addr = ja;
    mem_ack = ack; mem_rdata = rd;
    model_step(rdy, br, jmp, ja, ack, rd);
    @(posedge clk);
    @(negedge clk);
    chk("mem_req", mem_req, m_req);
    if (m_req) chk("mem_addr", mem_addr, m_addr);
    chk("ir_valid", ir_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("ir_pc", ir_pc, mq[0].pc);
      chk("ir_out", ir_out, mq[0].instr);
    end
  endtask

  initial begin
    bit found;
    reset = 1; ir_ready = 0; br_take = 0; jmp_take = 0; jmp_addr = 0;
    mem_ack = 0; mem_rdata = 0;
    w_reset = 1; w_ir_ready = 0; w_br_take = 0; w_jmp_take = 0; w_jmp_addr = 0;
    w_mem_ack = 0; w_mem_rdata = 0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_valid", ir_valid, 0);
    chk("rst_ir", ir_out, 16'h0000);
    chk("rst_pc", ir_pc, 16'h0000);
    reset = 0;
    cycle(0, 0, 0, 0, 0, 0);
    chk("rel_addr", mem_addr, 16'h0000);

    // zero-wait stream, one instruction per cycle
    repeat (10) cycle(1, 0, 0, 0, m_req, m_addr + 16'h1000);

    // stall: queue fills to two, request drops, one pop re-requests
    repeat (6) cycle(0, 0, 0, 0, m_req, m_addr + 16'h1000);
    chk("stall_req", mem_req, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("refill_req", mem_req, 1);

    // async reset mid-cycle, then walk the stream to pc 5 and branch back by 2
    reset = 1;
    #1;
    chk("async_req", mem_req, 0);
    chk("async_valid", ir_valid, 0);
    chk("async_addr", mem_addr, 16'h0000);
    @(negedge clk);
    reset = 0;
    model_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mq.size() != 0 && mq[0].pc == 16'h0005) found = 1;
      else cycle(1, 0, 0, 0, m_req, (m_addr == 16'h0005) ? 16'h00FE : m_addr + 16'h1000);
    end
    chk("br_reach", found, 1);
    cycle(1, 1, 0, 0, m_req, m_addr + 16'h1000);
    chk("br_valid", ir_valid, 0);
    chk("br_req", mem_req, 1);
    chk("br_addr", mem_addr, 16'h0003);

    // jump while a fetch is pending: old address held, data discarded
    cycle(1, 0, 1, 16'h0010, m_req, 16'h0);
    chk("jmp_addr", mem_addr, 16'h0010);
    cycle(1, 0, 1, 16'h0040, 0, 16'h0);
    chk("drain_hold1", mem_addr, 16'h0010);
    cycle(1, 0, 0, 0, 0, 16'h0);
    chk("drain_hold2", mem_addr, 16'h0010);
    cycle(1, 0, 0, 0, 1, 16'hBEEF);
    chk("drain_valid", ir_valid, 0);
    chk("drain_next", mem_addr, 16'h0040);
    cycle(1, 0, 0, 0, 1, 16'h1234);
    chk("tgt_pc", ir_pc, 16'h0040);
    chk("tgt_ir", ir_out, 16'h1234);

    // randomized traffic with wait states, stray acks and redirects
    for (int i = 0; i < 3000; i++) begin
      bit          a, r, b, j;
      logic [15:0] ja, rd;
      a  = m_req ? bit'($urandom % 2) : bit'($urandom % 10 == 0);
      r  = ($urandom % 10) < 6;
      b  = ($urandom % 20) == 0;
      j  = ($urandom % 33) == 0;
      ja = 16'($urandom);
      rd = 16'($urandom);
      cycle(r, b, j, ja, a, rd);
    end

    // wrap-around instance
    @(negedge clk);
    w_reset = 0;
    @(posedge clk); @(negedge clk);
    chk("wrap_req0", w_mem_req, 1);
    chk("wrap_addr0", w_mem_addr, 16'hFFFF);
    w_mem_ack = 1; w_mem_rdata = 16'h0001;
    @(posedge clk); @(negedge clk);
    chk("wrap_addr1", w_mem_addr, 16'h0000);
    chk("wrap_pc", w_ir_pc, 16'hFFFF);
    w_mem_rdata = 16'h2222;
    @(posedge clk); @(negedge clk);
    chk("wrap_full", w_mem_req, 0);
    w_mem_ack = 0; w_br_take = 1;
    @(posedge clk); @(negedge clk);
    w_br_take = 0;
    chk("wrap_br_valid", w_ir_valid, 0);
    chk("wrap_br_req", w_mem_req, 1);
    chk("wrap_br_addr", w_mem_addr, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
